// File: rtl/cpu_pkg.sv
// Shared constants and the writeback-source encoding for the register-file write scheduler.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned NUM_REGS   = 4;

  // Identifies which writeback source was granted last; used for round-robin fairness.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter (ALU vs. load return) for the register-file write port.
// Grants are combinational; only the last-granted source is stored.
module wb_rr_arbiter
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_req_i,
  input  logic mem_req_i,
  output logic alu_gnt_o,
  output logic mem_gnt_o
);

  wb_src_e rr_last_q, rr_last_d;

  // Grant the lone requester, or on a tie the source not granted last time.
  always_comb begin
    alu_gnt_o = alu_req_i && (!mem_req_i || (rr_last_q == SRC_MEM));
    mem_gnt_o = mem_req_i && !alu_gnt_o;
    rr_last_d = rr_last_q;
    if (alu_gnt_o) begin
      rr_last_d = SRC_ALU;
    end else if (mem_gnt_o) begin
      rr_last_d = SRC_MEM;
    end
  end

  // Reset to MEM so the ALU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= SRC_MEM;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU and load writebacks onto the single
// registered write port, and keeps a pending-write scoreboard that stalls decode on
// RAW/WAW hazards (no bypass).
module regfile_wb_scheduler
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dst,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  input  logic                  iss_valid,
  input  logic                  iss_writes,
  input  logic [REG_ADDR_W-1:0] iss_dst,
  input  logic [REG_ADDR_W-1:0] iss_rs1,
  input  logic [REG_ADDR_W-1:0] iss_rs2,
  output logic                  iss_stall,
  output logic [REG_ADDR_W-1:0] rf_we,
  output logic                  rf_no_write,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [NUM_REGS-1:0]   pending
);

  logic                  alu_gnt, mem_gnt;
  logic                  wr_accept;
  logic [REG_ADDR_W-1:0] wr_dst;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rf_no_write_q, rf_no_write_d;
  logic [REG_ADDR_W-1:0] rf_we_q, rf_we_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  issue_set;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_req_i (alu_valid),
    .mem_req_i (mem_valid),
    .alu_gnt_o (alu_gnt),
    .mem_gnt_o (mem_gnt)
  );

  // Grant only goes to a valid requester, so ready doubles as the accept strobe.
  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // Select the accepted writeback for the port register.
  always_comb begin
    wr_accept = alu_gnt || mem_gnt;
    wr_dst    = alu_dst;
    wr_data   = alu_data;
    if (mem_gnt) begin
      wr_dst  = mem_dst;
      wr_data = mem_data;
    end
  end

  // Write-port next state: drive the accepted write, otherwise suppress and hold addr/data.
  always_comb begin
    rf_no_write_d = 1'b1;
    rf_we_d       = rf_we_q;
    rf_wdata_d    = rf_wdata_q;
    if (wr_accept) begin
      rf_no_write_d = 1'b0;
      rf_we_d       = wr_dst;
      rf_wdata_d    = wr_data;
    end
  end

  // Stall on RAW for either source or WAW on the destination; no forwarding path exists.
  always_comb begin
    iss_stall = iss_valid &&
                (pending_q[iss_rs1] || pending_q[iss_rs2] || (iss_writes && pending_q[iss_dst]));
  end

  assign issue_set = iss_valid && iss_writes && !iss_stall;

  // Scoreboard: clear on the edge that commits the port write, then set so a same-edge
  // issue to that register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (!rf_no_write_q) begin
      pending_d[rf_we_q] = 1'b0;
    end
    if (issue_set) begin
      pending_d[iss_dst] = 1'b1;
    end
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_no_write_q <= 1'b1;
      rf_we_q       <= '0;
      rf_wdata_q    <= '0;
      pending_q     <= '0;
    end else begin
      rf_no_write_q <= rf_no_write_d;
      rf_we_q       <= rf_we_d;
      rf_wdata_q    <= rf_wdata_d;
      pending_q     <= pending_d;
    end
  end

  assign rf_no_write   = rf_no_write_q;
  assign rf_we         = rf_we_q;
  assign rf_write_data = rf_wdata_q;
  assign pending       = pending_q;

endmodule
